// File: rtl/matmul_pkg.sv
// Shared types and helpers for the fixed-point matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Accumulator wide enough that N full-scale products plus a preload never wrap.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Largest signed value representable in dw bits.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in dw bits.
  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/matmul_fxp_mac.sv
// Signed fixed-point multiply-accumulate with floor shift and saturation.
module fxp_mac
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BIN_POS    = 8,
  parameter int ACC_W      = 35
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         first,
  input  logic                         acc_mode,
  input  logic signed [DATA_WIDTH-1:0] prev,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         sat
);

  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(sat_min(DATA_WIDTH));

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]        prod_x, preload, base, acc_d, acc_q, shifted;

  assign prod    = a * b;
  assign prod_x  = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  // Old element is brought up to accumulator scale so the new sum lands on it.
  assign preload = acc_mode ? ({{(ACC_W-DATA_WIDTH){prev[DATA_WIDTH-1]}}, prev} <<< BIN_POS)
                            : '0;
  assign shifted = acc_q >>> BIN_POS;

  // First product of an element starts from the preload instead of the running sum.
  always_comb begin
    base  = first ? preload : acc_q;
    acc_d = en ? (base + prod_x) : acc_q;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // Clamp the rescaled sum into the element range and flag clipping.
  always_comb begin
    res = shifted[DATA_WIDTH-1:0];
    sat = 1'b0;
    if (shifted > MAXV) begin
      res = MAXV[DATA_WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      res = MINV[DATA_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/matmul_param.sv
// Sequential NxN fixed-point matrix multiply: one MAC per cycle, one writeback per element.
module matmul_param
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        acc_mode,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix_b,
  output logic                                        ready,
  output logic                                        done,
  output logic                                        overflow,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mul
);

  localparam int N     = MATRIX_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int MW    = N * N * DW;
  localparam int CW    = $clog2(N);
  localparam int ACC_W = acc_width(DW, N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] i_q, j_q, k_q;
  logic [MW-1:0] a_q, b_q, mul_q;
  logic          mode_q, ovf_q, live_q;
  logic          accept, mac_en, wb_en;
  logic signed [DW-1:0] a_el, b_el, prev_el, res;
  logic          sat;
  int            idx_ij, idx_ik, idx_kj;

  assign accept   = start & ready;
  assign mul      = mul_q;
  assign overflow = ovf_q;

  assign idx_ij  = int'(i_q) * N + int'(j_q);
  assign idx_ik  = int'(i_q) * N + int'(k_q);
  assign idx_kj  = int'(k_q) * N + int'(j_q);
  assign a_el    = a_q[idx_ik*DW +: DW];
  assign b_el    = b_q[idx_kj*DW +: DW];
  assign prev_el = mul_q[idx_ij*DW +: DW];

  // State register; live_q keeps ready low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state: N MAC cycles then one WB per element, DONE after the last element.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_MAC;
      S_MAC:  if (k_q == LAST) state_d = S_WB;
      S_WB:   state_d = (i_q == LAST && j_q == LAST) ? S_DONE : S_MAC;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    ready  = 1'b0;
    done   = 1'b0;
    mac_en = 1'b0;
    wb_en  = 1'b0;
    unique case (state_q)
      S_IDLE: ready  = live_q;
      S_MAC:  mac_en = 1'b1;
      S_WB:   wb_en  = 1'b1;
      S_DONE: done   = 1'b1;
      default: ;
    endcase
  end

  // Element indices: k walks the dot product, j then i walk the result row-major.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (mac_en) begin
      k_q <= (k_q == LAST) ? '0 : k_q + CW'(1);
    end else if (wb_en) begin
      if (j_q == LAST) begin
        j_q <= '0;
        i_q <= i_q + CW'(1);
      end else begin
        j_q <= j_q + CW'(1);
      end
    end
  end

  // Operand capture at acceptance so later input changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      a_q    <= matrix_a;
      b_q    <= matrix_b;
      mode_q <= acc_mode;
    end
  end

  // Result element and sticky overflow are only touched in their WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (wb_en) begin
      mul_q[idx_ij*DW +: DW] <= res;
      if (sat) ovf_q <= 1'b1;
    end
  end

  fxp_mac #(
    .DATA_WIDTH (DW),
    .BIN_POS    (BIN_POS),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (mac_en),
    .first    (k_q == '0),
    .acc_mode (mode_q),
    .prev     (prev_el),
    .a        (a_el),
    .b        (b_el),
    .res      (res),
    .sat      (sat)
  );

endmodule

// File: tb/tb_matmul_param.sv
// Scoreboard bench for matmul_param at N=2, 16-bit elements, 8 fractional bits.
module tb_matmul_param;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int MW = N * N * DW;

  typedef struct {
    logic [MW-1:0] m;
    logic          ov;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          acc_mode = 1'b0;
  logic [MW-1:0] matrix_a = '0;
  logic [MW-1:0] matrix_b = '0;
  logic          ready, done, overflow;
  logic [MW-1:0] mul;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;

  matmul_param #(.DATA_WIDTH(DW), .BIN_POS(8), .MATRIX_SIZE(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .acc_mode (acc_mode),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .ready    (ready),
    .done     (done),
    .overflow (overflow),
    .mul      (mul)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MW-1:0] pk(input logic [15:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL spurious_done: got done=1 at cycle %0d want no pulse", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mul", mul, e.m);
        chk("overflow", MW'(overflow), MW'(e.ov));
        chk("latency", MW'(cyc - e.acc), MW'(12));
      end
    end
  end

  // Issue one operation at the next idle slot and queue its expected outcome.
  task automatic issue(input logic [MW-1:0] a, b, input logic mode,
                       input logic [MW-1:0] em, input logic eov);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: got ready=0 want 1");
    end
    matrix_a = a; matrix_b = b; acc_mode = mode; start = 1'b1;
    e.m = em; e.ov = eov; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: got no done want done within 100 cycles");
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  logic [MW-1:0] ID, BV, B2, Z;
  initial begin
    ID = pk(16'h0100, 16'h0000, 16'h0000, 16'h0100);
    BV = pk(16'h0180, 16'hFF00, 16'h0040, 16'h0300);
    B2 = pk(16'h0300, 16'hFE00, 16'h0080, 16'h0600);
    Z  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", MW'(ready), MW'(0));
    chk("rst_done", MW'(done), MW'(0));
    chk("rst_ovf", MW'(overflow), MW'(0));
    chk("rst_mul", mul, Z);
    rst = 1'b0;
    #1 chk("ready_before_edge", MW'(ready), MW'(0));
    @(negedge clk);
    chk("ready_after_edge", MW'(ready), MW'(1));

    // Identity, signed floor, saturation, overflow clear, accumulate.
    issue(ID, BV, 1'b0, BV, 1'b0); drain();
    issue(pk(16'hFE80, 0, 0, 0), pk(16'h0201, 0, 0, 0), 1'b0,
          pk(16'hFCFE, 0, 0, 0), 1'b0); drain();
    issue({4{16'h7F00}}, {4{16'h7F00}}, 1'b0, {4{16'h7FFF}}, 1'b1); drain();
    chk("ovf_held", MW'(overflow), MW'(1));
    issue(ID, BV, 1'b0, BV, 1'b0); drain();
    issue(ID, BV, 1'b1, B2, 1'b0); drain();

    // Start while busy, with inputs changed after acceptance, must be ignored.
    issue(ID, BV, 1'b0, BV, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_ready", MW'(ready), MW'(0));
    matrix_a = {4{16'h7F00}}; matrix_b = {4{16'h7F00}}; acc_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    // Reset mid-operation discards the result and produces no done.
    issue(ID, pk(16'h0011, 16'h0022, 16'h0033, 16'h0044), 1'b0, Z, 1'b0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_mul", mul, Z);
    chk("midrst_done", MW'(done), MW'(0));
    chk("midrst_ready", MW'(ready), MW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_back", MW'(ready), MW'(1));
    repeat (20) @(negedge clk);
    issue(ID, BV, 1'b0, BV, 1'b0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop guard.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
